// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: synchronises and debounces raw set/clear requests and turns
// them into clean, mutually exclusive s/r pulses for a gated-NAND SR latch.
// Latency: a raw request first sampled at edge 0 drives s/r high after edge
// 2+DEBOUNCE+1. There is no backpressure. Requests that arrive while a pulse
// or gap is active wait in one pending bit per channel and are never dropped.
// Ports: clk/rst_n (async active-low); set_in/clr_in raw requests; q_fb latch
//   q feedback; s/r latch drives; busy; q_exp expected latch state;
//   conflict (1-cycle pulse); mismatch (sticky feedback error).
module sr_drive_ctrl #(
   parameter int DEBOUNCE = 4,
   parameter int PULSE_W  = 2,
   parameter int GAP_W    = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_in,
   input  logic clr_in,
   input  logic q_fb,
   output logic s,
   output logic r,
   output logic busy,
   output logic q_exp,
   output logic conflict,
   output logic mismatch
);

   localparam int              CW       = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE);
   localparam logic [3:0]      PW_LAST  = 4'(PULSE_W - 1);
   localparam logic [3:0]      GAP_LAST = 4'(GAP_W - 1);

   typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GAP} state_t;

   logic [1:0]    set_sync, clr_sync;
   logic [CW-1:0] cnt_s, cnt_r;
   logic          lvl_s_d, lvl_r_d;
   logic          lvl_s, lvl_r, ev_s, ev_r;
   logic          pend_s, pend_r;
   state_t        state, state_nxt;
   logic [3:0]    tmr, tmr_nxt;
   logic          launch_s, launch_r, chk;

   // Two-flop synchronisers ahead of all other logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_sync <= 2'b00;
         clr_sync <= 2'b00;
      end else begin
         set_sync <= {set_sync[0], set_in};
         clr_sync <= {clr_sync[0], clr_in};
      end
   end

   // Debounce counters saturate at DEBOUNCE; any low sample restarts them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_s   <= '0;
         cnt_r   <= '0;
         lvl_s_d <= 1'b0;
         lvl_r_d <= 1'b0;
      end else begin
         if (!set_sync[1])         cnt_s <= '0;
         else if (cnt_s != CNT_MAX) cnt_s <= cnt_s + CW'(1);
         if (!clr_sync[1])         cnt_r <= '0;
         else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CW'(1);
         lvl_s_d <= lvl_s;
         lvl_r_d <= lvl_r;
      end
   end

   assign lvl_s = (cnt_s == CNT_MAX);
   assign lvl_r = (cnt_r == CNT_MAX);
   assign ev_s  = lvl_s & ~lvl_s_d;
   assign ev_r  = lvl_r & ~lvl_r_d;

   // Command sequencer. tmr counts cycles spent in the current DRIVE/GAP state.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      launch_s  = 1'b0;
      launch_r  = 1'b0;
      chk       = 1'b0;
      case (state)
         IDLE: begin
            // Clear wins over set when both are waiting.
            if (pend_r) begin
               state_nxt = DRIVE_R;
               launch_r  = 1'b1;
               tmr_nxt   = 4'd0;
            end else if (pend_s) begin
               state_nxt = DRIVE_S;
               launch_s  = 1'b1;
               tmr_nxt   = 4'd0;
            end
         end
         DRIVE_S, DRIVE_R: begin
            if (tmr == PW_LAST) begin
               state_nxt = GAP;
               tmr_nxt   = 4'd0;
            end else begin
               tmr_nxt = tmr + 4'd1;
            end
         end
         GAP: begin
            if (tmr == GAP_LAST) begin
               state_nxt = IDLE;
               tmr_nxt   = 4'd0;
               chk       = 1'b1;
            end else begin
               tmr_nxt = tmr + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tmr      <= 4'd0;
         pend_s   <= 1'b0;
         pend_r   <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         busy     <= 1'b0;
         q_exp    <= 1'b0;
         conflict <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         state    <= state_nxt;
         tmr      <= tmr_nxt;
         // Launch clears first so an event in the launch cycle re-queues.
         pend_s   <= (pend_s & ~launch_s) | (ev_s & ~ev_r);
         pend_r   <= (pend_r & ~launch_r) | ev_r;
         // Outputs are registered from the next state so s/r never glitch.
         s        <= (state_nxt == DRIVE_S);
         r        <= (state_nxt == DRIVE_R);
         busy     <= (state_nxt != IDLE);
         conflict <= ev_s & ev_r;
         if (launch_s) q_exp <= 1'b1;
         if (launch_r) q_exp <= 1'b0;
         if (chk && (q_fb != q_exp)) mismatch <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
module tb_sr_drive_ctrl;

   localparam int D  = 4;
   localparam int PW = 2;
   localparam int GW = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_in = 1'b0;
   logic clr_in = 1'b0;
   logic q_fb;
   logic s, r, busy, q_exp, conflict, mismatch;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sr_drive_ctrl #(.DEBOUNCE(D), .PULSE_W(PW), .GAP_W(GW)) dut (
      .clk(clk), .rst_n(rst_n), .set_in(set_in), .clr_in(clr_in), .q_fb(q_fb),
      .s(s), .r(r), .busy(busy), .q_exp(q_exp), .conflict(conflict),
      .mismatch(mismatch)
   );

   // Behavioural SR latch downstream; fb_break forces a stuck-at-0 q.
   logic latch_q = 1'b0;
   logic fb_break = 1'b0;
   always @(s, r) begin
      if (s) latch_q = 1'b1;
      else if (r) latch_q = 1'b0;
   end
   assign q_fb = fb_break ? 1'b0 : latch_q;

   // Reference model: edge-indexed schedule. run_* counts consecutive high
   // samples (delayed by the synchroniser depth); a request is accepted the
   // moment a run reaches exactly D. Each command occupies PW+GW cycles
   // from its launch edge, and the next launch is allowed one edge later.
   int   cyc = 0, le = -100, free_at = 0, run_s = 0, run_r = 0;
   logic [2:0] sh_s = '0, sh_r = '0;
   logic pend_s_m = 0, pend_r_m = 0, dir_m = 0, qexp_m = 0, conf_m = 0, mm_m = 0;
   logic ev_s_m, ev_r_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; le = -100; free_at = 0; run_s = 0; run_r = 0;
         sh_s = '0; sh_r = '0;
         pend_s_m = 0; pend_r_m = 0; dir_m = 0; qexp_m = 0; conf_m = 0; mm_m = 0;
      end else begin
         cyc++;
         run_s = sh_s[2] ? run_s + 1 : 0;
         run_r = sh_r[2] ? run_r + 1 : 0;
         ev_s_m = (run_s == D);
         ev_r_m = (run_r == D);
         sh_s = {sh_s[1:0], set_in};
         sh_r = {sh_r[1:0], clr_in};
         if (cyc == le + PW + GW && q_fb !== qexp_m) mm_m = 1'b1;
         if (cyc >= free_at && (pend_r_m || pend_s_m)) begin
            le = cyc;
            free_at = cyc + PW + GW + 1;
            if (pend_r_m) begin dir_m = 1'b0; pend_r_m = 1'b0; end
            else begin dir_m = 1'b1; pend_s_m = 1'b0; end
            qexp_m = dir_m;
         end
         if (ev_r_m) pend_r_m = 1'b1;
         if (ev_s_m && !ev_r_m) pend_s_m = 1'b1;
         conf_m = ev_s_m && ev_r_m;
      end
   end

   logic [5:0] exp_vec, act_vec;
   assign exp_vec = { dir_m  && (cyc >= le) && (cyc < le + PW),
                      !dir_m && (cyc >= le) && (cyc < le + PW),
                      (cyc >= le) && (cyc < le + PW + GW),
                      qexp_m, conf_m, mm_m };
   assign act_vec = {s, r, busy, q_exp, conflict, mismatch};

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      settle(3);
      n_run++;
      if (act_vec !== 6'b000000) begin
         n_fail++;
         $display("FAIL reset_state: got %b want 000000", act_vec);
      end
      rst_n = 1'b1;
      settle(2);
      n_run++;
      if (act_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL reset_release: got %b want %b", act_vec, exp_vec);
      end
   endtask

   task automatic test_single_set();
      set_in = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         n_run++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL single_set_model k=%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_run++;
         if ({s, r, busy} !== {(k == 7 || k == 8), 1'b0, (k >= 7 && k <= 9)}) begin
            n_fail++;
            $display("FAIL single_set_timing k=%0d: s/r/busy=%b%b%b", k, s, r, busy);
         end
      end
      n_run++;
      if (q_exp !== 1'b1) begin
         n_fail++;
         $display("FAIL single_set_qexp: got %b want 1", q_exp);
      end
      set_in = 1'b0;
      settle(6);
   endtask

   task automatic test_bounce();
      logic act;
      act = 1'b0;
      for (int k = 0; k < 16; k++) begin
         set_in = (k < 3);
         tick();
         act = act | s | r | busy;
         n_run++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL bounce_model k=%0d: got %b want %b", k, act_vec, exp_vec);
         end
      end
      n_run++;
      if (act !== 1'b0 || q_exp !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_quiet: activity=%b q_exp=%b want 0/1", act, q_exp);
      end
   endtask

   task automatic test_conflict();
      int nc, ns, nr;
      nc = 0; ns = 0; nr = 0;
      set_in = 1'b1;
      clr_in = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         nc += int'(conflict); ns += int'(s); nr += int'(r);
         n_run++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL conflict_model k=%0d: got %b want %b", k, act_vec, exp_vec);
         end
      end
      n_run++;
      if (nc != 1 || ns != 0 || nr != PW || q_exp !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_counts: conf=%0d s=%0d r=%0d q_exp=%b want 1/0/2/0",
                  nc, ns, nr, q_exp);
      end
      set_in = 1'b0;
      clr_in = 1'b0;
      settle(6);
   endtask

   task automatic test_clr_during_s();
      set_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (k == 1) clr_in = 1'b1;
         n_run++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL clr_during_s_model k=%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_run++;
         if ({s, r} !== {(k == 7 || k == 8), (k == 11 || k == 12)}) begin
            n_fail++;
            $display("FAIL clr_during_s_timing k=%0d: s/r=%b%b", k, s, r);
         end
      end
      set_in = 1'b0;
      clr_in = 1'b0;
      settle(8);
   endtask

   task automatic test_random();
      int hs, hr, bad;
      hs = 0; hr = 0; bad = 0;
      for (int i = 0; i < 600; i++) begin
         if (hs == 0) begin set_in = 1'($urandom_range(0, 1)); hs = int'($urandom_range(1, 12)); end
         else hs--;
         if (hr == 0) begin clr_in = 1'($urandom_range(0, 1)); hr = int'($urandom_range(1, 12)); end
         else hr--;
         tick();
         if (s && r) bad++;
         n_run++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL random_model i=%0d: got %b want %b", i, act_vec, exp_vec);
         end
      end
      n_run++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL random_exclusive: s&r high in %0d cycles, want 0", bad);
      end
      set_in = 1'b0;
      clr_in = 1'b0;
      settle(24);
   endtask

   task automatic test_mismatch();
      fb_break = 1'b1;
      set_in = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_run++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL mismatch_model k=%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_run++;
         if (mismatch !== (k >= 10)) begin
            n_fail++;
            $display("FAIL mismatch_timing k=%0d: got %b want %b", k, mismatch, (k >= 10));
         end
      end
      set_in = 1'b0;
      settle(4);
      fb_break = 1'b0;
      clr_in = 1'b1;
      settle(14);
      clr_in = 1'b0;
      settle(4);
      set_in = 1'b1;
      settle(14);
      set_in = 1'b0;
      settle(4);
      n_run++;
      if (mismatch !== 1'b1 || act_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL mismatch_sticky: got %b want %b", act_vec, exp_vec);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int n;
      int seen;
      n = 0;
      seen = 0;
      clr_in = 1'b1;
      while (!r && n < 20) begin
         tick();
         n++;
      end
      n_run++;
      if (r !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pulse_wait: r never rose within 20 cycles");
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      clr_in = 1'b0;
      #1;
      n_run++;
      if (act_vec !== 6'b000000) begin
         n_fail++;
         $display("FAIL mid_pulse_async: got %b want 000000", act_vec);
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         seen += int'(s | r | busy);
         n_run++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL mid_pulse_after k=%0d: got %b want %b", k, act_vec, exp_vec);
         end
      end
      n_run++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL mid_pulse_replay: activity in %0d cycles, want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_single_set();
      test_bounce();
      test_conflict();
      test_clr_during_s();
      test_random();
      test_mismatch();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Upstream driver for the gated-NAND SR flip-flop stage (sr_ff).
- Takes two raw, asynchronous, bouncy request lines (set and clear) and synchronises and debounces them.
- Converts debounced rising edges into clean, mutually exclusive, fixed-width s/r pulses aligned to clk, so the s=r=1 forbidden input never reaches the latch.
- Tracks the expected latch state and checks it against the latch q output fed back in.

Parameters:
- DEBOUNCE, 4: consecutive synchronised-high cycles needed to accept a request (1..255).
- PULSE_W, 2: cycles s or r is held high per command (1..15).
- GAP_W, 1: cycles with s=r=0 enforced after every pulse before the next pulse or the feedback check (1..15).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set_in  input  1  raw set request, asynchronous to clk.
- clr_in  input  1  raw clear request, asynchronous to clk.
- q_fb  input  1  q output of the downstream SR flip-flop.
- s  output  1  set drive to the flip-flop.
- r  output  1  reset drive to the flip-flop.
- busy  output  1  high while in DRIVE_S, DRIVE_R or GAP.
- q_exp  output  1  expected flip-flop state.
- conflict  output  1  one-cycle pulse when set and clear events are accepted in the same cycle.
- mismatch  output  1  sticky error flag: q_fb != q_exp at a feedback check.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Sync flops, debounce counters, pending bits and FSM go to IDLE.
  - s=0, r=0, busy=0, q_exp=0, conflict=0, mismatch=0.
  - If reset asserts mid-pulse, s/r drop immediately. No command is replayed after reset release.
- Synchroniser: each raw input passes through 2 flops before any other logic.
- Debounce, per channel:
  - A counter of width clog2(DEBOUNCE+1) increments while the synchronised input is 1 and saturates at DEBOUNCE.
  - Any 0 clears the counter.
  - The debounced level is 1 while the counter equals DEBOUNCE.
  - An event is the 0->1 transition of the debounced level, one cycle wide.
  - A held input produces exactly one event. A glitch shorter than DEBOUNCE cycles produces none.
- Latency: raw input first sampled high at edge 0 and held stable -> s (or r) is high after edge 2+DEBOUNCE+1, i.e. edge 7 with defaults.
- Pending bits (pend_s, pend_r):
  - An event sets its pending bit.
  - A bit clears when its command is launched.
  - An event arriving while its bit is already set is merged.
- Conflict handling:
  - If set and clear events occur in the same cycle, conflict pulses for 1 cycle.
  - Only pend_r is set (clear has priority).
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE: if pend_r -> DRIVE_R; else if pend_s -> DRIVE_S. The pending bit clears on that transition.
  - DRIVE_S: s=1, r=0 for exactly PULSE_W cycles, then GAP. q_exp<=1 on entry.
  - DRIVE_R: r=1, s=0 for exactly PULSE_W cycles, then GAP. q_exp<=0 on entry.
  - GAP: s=r=0 for exactly GAP_W cycles, then the feedback check, then IDLE.
    - Feedback check: on the last GAP cycle, if q_fb != q_exp, mismatch<=1.
    - Pending commands are served from IDLE on the next cycle, clear first.
- Invariants:
  - s and r are never 1 in the same cycle.
  - Any two pulses are separated by at least GAP_W+1 zero cycles (GAP plus one IDLE cycle).
- mismatch clears only on reset.
- Events arriving during DRIVE or GAP are queued via their pending bits, never dropped. At most one queued command per channel.
- A repeated same-direction command is still driven and checked.

Test Plan:
- Reset release, then set_in held high from edge 0 (defaults) -> s=1 on edges 7-8, GAP at edge 9, back in IDLE; q_exp=1, busy high for 3 cycles, r stays 0.
- set_in high for 3 cycles then low (bounce, DEBOUNCE=4) -> no s/r activity, busy stays 0, q_exp unchanged.
- set_in and clr_in rise on the same edge -> conflict high for 1 cycle; only an r pulse (2 cycles); q_exp=0; s never 1.
- clr_in event during an active s pulse -> s completes its 2 cycles, 1 GAP cycle and 1 IDLE cycle follow, then r for 2 cycles; s&r never both high.
- Set command with q_fb tied to 0 -> mismatch=1 after the GAP cycle and stays 1 through later correct commands, until rst_n=0.
- rst_n pulsed low during the 2nd cycle of an r pulse -> r drops asynchronously; all outputs 0 after release; no pulse resumes.
